// File: rtl/itof_pipe.sv
// itof_pipe: IW-bit signed/unsigned integer to IEEE-754 binary32 with four rounding modes and an inexact flag.
// Latency: 3 cycles (S1 magnitude, S2 normalise, S3 round); one result per cycle sustained.
// Backpressure: elastic valid/ready stages that collapse bubbles; holds 3 results, in_ready falls only when all are full.
module itof_pipe #(
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data,
    input  logic          in_signed,
    input  logic [1:0]    in_rm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_inexact
);

    localparam int PW = $clog2(IW);
    // Normalised magnitude followed by 26 zero bits, so the hidden bit, 23 mantissa bits,
    // the guard bit and at least one sticky bit always exist, whatever IW is.
    localparam int EW = IW + 26;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    // Stage 1 state: sign and magnitude of the operand.
    logic          s1_valid;
    logic          s1_sign;
    logic [IW-1:0] s1_mag;
    logic [1:0]    s1_rm;

    // Stage 2 state: normalised fields before rounding.
    logic          s2_valid;
    logic          s2_sign;
    logic          s2_zero;
    logic [7:0]    s2_exp;
    logic [22:0]   s2_mant;
    logic          s2_guard;
    logic          s2_sticky;
    logic [1:0]    s2_rm;

    // Stage 3 state: the rounded result presented on the output.
    logic          s3_valid;
    logic [31:0]   s3_data;
    logic          s3_inexact;

    // Stage load enables: a stage may load when it is empty or its content moves on this cycle.
    logic en1, en2, en3;

    assign en3       = ~s3_valid | out_ready;
    assign en2       = ~s2_valid | en3;
    assign en1       = ~s1_valid | en2;
    assign in_ready  = rstn & en1;

    assign out_valid   = s3_valid;
    assign out_data    = s3_data;
    assign out_inexact = s3_inexact;

    // S1 combinational: sign extraction and absolute value (IW-bit unsigned, so -2^(IW-1) stays exact).
    logic          c1_sign;
    logic [IW-1:0] c1_mag;

    always_comb begin
        c1_sign = in_signed & in_data[IW-1];
        c1_mag  = c1_sign ? (-in_data) : in_data;
    end

    // S1 register: capture operand on input transfer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_rm    <= '0;
        end else if (en1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= c1_sign;
                s1_mag  <= c1_mag;
                s1_rm   <= in_rm;
            end
        end
    end

    // S2 combinational: leading-one search, normalising shift, guard and sticky extraction.
    logic [PW-1:0] c2_lead;
    logic [PW-1:0] c2_shamt;
    logic [IW-1:0] c2_norm;
    logic [EW-1:0] c2_ext;
    logic [7:0]    c2_exp;

    always_comb begin
        c2_lead = '0;
        for (int i = 0; i < IW; i++) begin
            if (s1_mag[i]) begin
                c2_lead = i[PW-1:0];
            end
        end
        c2_shamt = PW'(IW - 1) - c2_lead;
        c2_norm  = s1_mag << c2_shamt;
        c2_ext   = {c2_norm, 26'd0};
        c2_exp   = 8'd127 + 8'(c2_lead);
    end

    // S2 register: normalised significand fields; a zero operand leaves no leading one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_zero   <= 1'b0;
            s2_exp    <= '0;
            s2_mant   <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_rm     <= '0;
        end else if (en2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign   <= s1_sign;
                s2_zero   <= ~c2_ext[EW-1];
                s2_exp    <= c2_exp;
                s2_mant   <= c2_ext[EW-2 -: 23];
                s2_guard  <= c2_ext[EW-25];
                s2_sticky <= |c2_ext[EW-26:0];
                s2_rm     <= s1_rm;
            end
        end
    end

    // S3 combinational: rounding increment; a mantissa carry-out bumps the exponent and leaves mantissa 0.
    logic        c3_inc;
    logic [23:0] c3_sum;
    logic [7:0]  c3_exp;
    logic [31:0] c3_data;
    logic        c3_inexact;

    always_comb begin
        case (s2_rm)
            RM_RNE:  c3_inc = s2_guard & (s2_sticky | s2_mant[0]);
            RM_RTZ:  c3_inc = 1'b0;
            RM_RDN:  c3_inc = s2_sign & (s2_guard | s2_sticky);
            RM_RUP:  c3_inc = ~s2_sign & (s2_guard | s2_sticky);
            default: c3_inc = 1'b0;
        endcase
        c3_sum     = {1'b0, s2_mant} + {23'd0, c3_inc};
        c3_exp     = s2_exp + {7'd0, c3_sum[23]};
        c3_data    = s2_zero ? 32'd0 : {s2_sign, c3_exp, c3_sum[22:0]};
        c3_inexact = s2_guard | s2_sticky;
    end

    // S3 register: output holding register, frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s3_valid   <= 1'b0;
            s3_data    <= '0;
            s3_inexact <= 1'b0;
        end else if (en3) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_data    <= c3_data;
                s3_inexact <= c3_inexact;
            end
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Bench for itof_pipe: directed vectors plus a randomised backpressure run, checked against a
// value-level reference conversion (integer arithmetic with remainder/half comparisons).
// Extra IW=16 and IW=64 instances cover the width extremes with directed vectors.
module tb_itof_pipe;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic [1:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;

    logic        v16, v64, rdy16, rdy64, ovld16, ovld64, oinx16, oinx64;
    logic [31:0] od16, od64;
    logic [63:0] sm_data;
    logic        sm_sgn;
    logic [1:0]  sm_rm;

    itof_pipe #(.IW(32)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_signed(in_signed), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_inexact(out_inexact)
    );

    itof_pipe #(.IW(16)) dut16 (
        .clk(clk), .rstn(rstn),
        .in_valid(v16), .in_ready(rdy16), .in_data(sm_data[15:0]),
        .in_signed(sm_sgn), .in_rm(sm_rm),
        .out_valid(ovld16), .out_ready(1'b1),
        .out_data(od16), .out_inexact(oinx16)
    );

    itof_pipe #(.IW(64)) dut64 (
        .clk(clk), .rstn(rstn),
        .in_valid(v64), .in_ready(rdy64), .in_data(sm_data),
        .in_signed(sm_sgn), .in_rm(sm_rm),
        .out_valid(ovld64), .out_ready(1'b1),
        .out_data(od64), .out_inexact(oinx64)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: exact integer value, then round q = floor(mag / 2^sh) by comparing the
    // discarded remainder with half an ulp. Returns {inexact, binary32}.
    function automatic logic [32:0] model(input logic [63:0] v, input bit sgn, input int w,
                                          input logic [1:0] rm);
        logic [63:0] mask, mag, q, rem, half;
        bit neg, up;
        int p, sh;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        v    = v & mask;
        neg  = sgn && v[w-1];
        mag  = neg ? (64'd0 - (v | ~mask)) : v;
        if (mag == 64'd0) return 33'd0;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        if (p <= 23) begin
            q = mag << (23 - p); rem = 64'd0; half = 64'd0;
        end else begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
        end
        case (rm)
            2'd0:    up = (rem > half) || (rem == half && rem != 0 && q[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = neg && (rem != 0);
            default: up = !neg && (rem != 0);
        endcase
        if (up) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            p = p + 1;
        end
        return {rem != 64'd0, neg, 8'(p + 127), q[22:0]};
    endfunction

    typedef struct packed {
        logic [31:0] data;
        logic        sgn;
        logic [1:0]  rm;
        logic [31:0] res;
        logic        inx;
    } vec_t;

    vec_t tbl [0:13] = '{
        '{32'h0000_0001, 1'b1, 2'd0, 32'h3F80_0000, 1'b0},
        '{32'hFFFF_FFFF, 1'b1, 2'd0, 32'hBF80_0000, 1'b0},
        '{32'h0000_0000, 1'b1, 2'd0, 32'h0000_0000, 1'b0},
        '{32'h0000_0000, 1'b1, 2'd2, 32'h0000_0000, 1'b0},
        '{32'h8000_0000, 1'b1, 2'd0, 32'hCF00_0000, 1'b0},
        '{32'h0100_0001, 1'b1, 2'd0, 32'h4B80_0000, 1'b1},
        '{32'h0100_0001, 1'b1, 2'd3, 32'h4B80_0001, 1'b1},
        '{32'h0100_0003, 1'b1, 2'd0, 32'h4B80_0002, 1'b1},
        '{32'hFEFF_FFFF, 1'b1, 2'd2, 32'hCB80_0001, 1'b1},
        '{32'hFEFF_FFFF, 1'b1, 2'd1, 32'hCB80_0000, 1'b1},
        '{32'h7FFF_FFFF, 1'b1, 2'd0, 32'h4F00_0000, 1'b1},
        '{32'h7FFF_FFFF, 1'b1, 2'd1, 32'h4EFF_FFFF, 1'b1},
        '{32'hFFFF_FFFF, 1'b0, 2'd0, 32'h4F80_0000, 1'b1},
        '{32'h0000_0005, 1'b1, 2'd0, 32'h40A0_0000, 1'b0}
    };

    typedef struct {
        logic [32:0] exp;
        int          enq;
        bit          seen;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    bit   strict_lat = 1'b0;
    bit   prev_stall = 1'b0;
    logic [32:0] prev_out;
    int   or_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0

    // Consumer-side ready generation, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Compare process: sampled on the falling edge, reflects the transfers of the next rising edge.
    always @(negedge clk) begin
        bit   exp_rdy;
        ent_t e;
        cyc++;
        if (!rstn) begin
            chk(in_ready == 1'b0, "in_ready_in_reset", in_ready, 0);
            q.delete();
            prev_stall = 1'b0;
        end else begin
            exp_rdy = (q.size() < 3) || out_ready;
            chk(in_ready == exp_rdy, "in_ready", in_ready, exp_rdy);
            if (prev_stall)
                chk(out_valid && {out_inexact, out_data} == prev_out, "stall_stable",
                    {out_valid, out_inexact, out_data}, {1'b1, prev_out});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_output", {out_inexact, out_data}, 0);
                end else begin
                    chk({out_inexact, out_data} == q[0].exp, "result",
                        {out_inexact, out_data}, q[0].exp);
                    if (!q[0].seen) begin
                        q[0].seen = 1'b1;
                        if (strict_lat)
                            chk(cyc - q[0].enq == 3, "latency", cyc - q[0].enq, 3);
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_inexact, out_data};
            if (in_valid && in_ready) begin
                e.exp  = model({32'd0, in_data}, in_signed, 32, in_rm);
                e.enq  = cyc;
                e.seen = 1'b0;
                q.push_back(e);
            end
        end
    end

    // Present one operand (called just after a rising edge) and hold it until accepted.
    task automatic send(input logic [31:0] d, input bit sgn, input logic [1:0] rm);
        bit acc;
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = sgn;
        in_rm     = rm;
        acc       = 1'b0;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk(1'b0, "send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            done = (q.size() == 0) && !out_valid;
        end
        if (!done) chk(1'b0, "drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_small(input bit is64, input logic [63:0] d, input bit sgn,
                             input logic [1:0] rm, input logic [31:0] er, input bit ei,
                             input string nm);
        bit   got;
        logic rdy;
        chk(model(d, sgn, is64 ? 64 : 16, rm) == {ei, er}, {nm, "_model"},
            model(d, sgn, is64 ? 64 : 16, rm), {ei, er});
        sm_data = d;
        sm_sgn  = sgn;
        sm_rm   = rm;
        if (is64) v64 = 1'b1; else v16 = 1'b1;
        @(negedge clk);
        rdy = is64 ? rdy64 : rdy16;
        chk(rdy == 1'b1, {nm, "_in_ready"}, rdy, 1);
        @(posedge clk);
        #1;
        v16 = 1'b0;
        v64 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = is64 ? ovld64 : ovld16;
        end
        chk(got, {nm, "_timeout"}, got, 1);
        if (got) begin
            if (is64) chk({oinx64, od64} == {ei, er}, nm, {oinx64, od64}, {ei, er});
            else      chk({oinx16, od16} == {ei, er}, nm, {oinx16, od16}, {ei, er});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk       = 1'b0;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        in_rm     = '0;
        out_ready = 1'b1;
        v16       = 1'b0;
        v64       = 1'b0;
        sm_data   = '0;
        sm_sgn    = 1'b0;
        sm_rm     = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk({out_valid, out_inexact, out_data} == 34'd0, "reset_outputs",
            {out_valid, out_inexact, out_data}, 0);
        rstn = 1'b1;

        // Pin the reference against hand-computed values.
        for (int i = 0; i < 14; i++)
            chk(model({32'd0, tbl[i].data}, tbl[i].sgn, 32, tbl[i].rm) == {tbl[i].inx, tbl[i].res},
                $sformatf("model_vec%0d", i),
                model({32'd0, tbl[i].data}, tbl[i].sgn, 32, tbl[i].rm), {tbl[i].inx, tbl[i].res});

        // Directed vectors back-to-back with out_ready held 1: exact latency, one per cycle.
        strict_lat = 1'b1;
        or_mode    = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) send(tbl[i].data, tbl[i].sgn, tbl[i].rm);
        in_valid = 1'b0;
        drain();

        // 20 back-to-back operands under random backpressure.
        strict_lat = 1'b0;
        or_mode    = 1;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (i % 4 == 0) d = 32'($urandom_range(0, 255));
            send(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        in_valid = 1'b0;
        or_mode  = 0;
        drain();

        // Reset with three results stuck in the pipe.
        or_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(32'h100 + 32'(i), 1'b1, 2'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk({out_valid, out_inexact, out_data} == 34'd0, "midflight_reset_outputs",
            {out_valid, out_inexact, out_data}, 0);
        or_mode    = 0;
        strict_lat = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(32'd5, 1'b1, 2'd0);
        in_valid = 1'b0;
        drain();

        // Width extremes.
        run_small(1'b0, 64'h8000, 1'b1, 2'd0, 32'hC700_0000, 1'b0, "iw16_min");
        run_small(1'b0, 64'hFFFF, 1'b0, 2'd0, 32'h477F_FF00, 1'b0, "iw16_umax");
        run_small(1'b1, 64'h8000_0000_0000_0000, 1'b1, 2'd0, 32'hDF00_0000, 1'b0, "iw64_min");
        run_small(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd0, 32'h5F80_0000, 1'b1, "iw64_umax");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
